// File: rtl/demux_lane_fifos.sv
// Two independent per-lane synchronous FIFOs behind the 1:2 byte demux, with flow-control flags.
// Optional DEMUX_FIFO_PAUSE_EN adds a registered pause output driven by either lane's almost_full.
module demux_lane_fifos #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] dataIn0,
    input  logic          validIn0,
    input  logic [DW-1:0] dataIn1,
    input  logic          validIn1,
    input  logic          pop0,
    input  logic          pop1,
    output logic [DW-1:0] dataOut0,
    output logic [DW-1:0] dataOut1,
    output logic          validOut0,
    output logic          validOut1,
    output logic          full0,
    output logic          full1,
    output logic          empty0,
    output logic          empty1,
    output logic          almost_full0,
    output logic          almost_full1,
    output logic          almost_empty0,
    output logic          almost_empty1,
    output logic          overflow,
`ifdef DEMUX_FIFO_PAUSE_EN
    output logic          pause,
`endif
    output logic          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem    [2][DEPTH];
    logic [AW-1:0] r_wr_ptr [2];
    logic [AW-1:0] r_rd_ptr [2];
    logic [CW-1:0] r_count  [2];
    logic [DW-1:0] r_dout   [2];
    logic          r_vout   [2];
    logic          r_ovf;
    logic          r_unf;

    logic [DW-1:0] w_din     [2];
    logic          w_vin     [2];
    logic          w_popreq  [2];
    logic          w_push    [2];
    logic          w_pop     [2];
    logic          w_full    [2];
    logic          w_empty   [2];
    logic          w_afull   [2];
    logic          w_aempty  [2];
    logic [CW-1:0] w_cnt_nxt [2];

    always_comb begin
        w_din[0]    = dataIn0;
        w_din[1]    = dataIn1;
        w_vin[0]    = validIn0;
        w_vin[1]    = validIn1;
        w_popreq[0] = pop0;
        w_popreq[1] = pop1;
    end

    // Flags decode only the registered count; a full lane still accepts a push when it is popped.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_full[i]    = (r_count[i] == CW'(DEPTH));
            w_empty[i]   = (r_count[i] == '0);
            w_afull[i]   = (r_count[i] >= CW'(AF_THRESH));
            w_aempty[i]  = (r_count[i] <= CW'(AE_THRESH));
            w_pop[i]     = w_popreq[i] && !w_empty[i];
            w_push[i]    = w_vin[i] && (!w_full[i] || w_popreq[i]);
            w_cnt_nxt[i] = r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
                r_dout[i]   <= '0;
                r_vout[i]   <= 1'b0;
            end
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_count[i] <= w_cnt_nxt[i];
                r_vout[i]  <= w_pop[i];
                if (w_push[i])
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                    r_dout[i]   <= r_mem[i][r_rd_ptr[i]];
                end
                if (w_vin[i] && w_full[i] && !w_popreq[i])
                    r_ovf <= 1'b1;
                if (w_popreq[i] && w_empty[i])
                    r_unf <= 1'b1;
            end
        end
    end

    // Storage is not reset; writes are still blocked while reset is asserted.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (reset && w_push[i])
                r_mem[i][r_wr_ptr[i]] <= w_din[i];
        end
    end

`ifdef DEMUX_FIFO_PAUSE_EN
    logic r_pause;

    always_ff @(posedge clk) begin
        if (!reset)
            r_pause <= 1'b0;
        else
            r_pause <= (w_cnt_nxt[0] >= CW'(AF_THRESH)) || (w_cnt_nxt[1] >= CW'(AF_THRESH));
    end

    assign pause = r_pause;
`endif

    assign dataOut0      = r_dout[0];
    assign dataOut1      = r_dout[1];
    assign validOut0     = r_vout[0];
    assign validOut1     = r_vout[1];
    assign full0         = w_full[0];
    assign full1         = w_full[1];
    assign empty0        = w_empty[0];
    assign empty1        = w_empty[1];
    assign almost_full0  = w_afull[0];
    assign almost_full1  = w_afull[1];
    assign almost_empty0 = w_aempty[0];
    assign almost_empty1 = w_aempty[1];
    assign overflow      = r_ovf;
    assign underflow     = r_unf;

endmodule

// File: tb/tb_demux_lane_fifos.sv
// Self-checking bench for demux_lane_fifos: queue-based reference model plus a vector table for fill/drain.
// Exercises the pause output when DEMUX_FIFO_PAUSE_EN is defined.
module tb_demux_lane_fifos;

    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dataIn0, dataIn1;
    logic       validIn0, validIn1, pop0, pop1;
    logic [7:0] dataOut0, dataOut1;
    logic       validOut0, validOut1;
    logic       full0, full1, empty0, empty1;
    logic       almost_full0, almost_full1, almost_empty0, almost_empty1;
    logic       overflow, underflow;
`ifdef DEMUX_FIFO_PAUSE_EN
    logic       pause;
`endif

    always #5 clk = ~clk;

    demux_lane_fifos #(.DW(8), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
        .clk(clk), .reset(reset),
        .dataIn0(dataIn0), .validIn0(validIn0), .dataIn1(dataIn1), .validIn1(validIn1),
        .pop0(pop0), .pop1(pop1),
        .dataOut0(dataOut0), .dataOut1(dataOut1), .validOut0(validOut0), .validOut1(validOut1),
        .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1),
        .almost_full0(almost_full0), .almost_full1(almost_full1),
        .almost_empty0(almost_empty0), .almost_empty1(almost_empty1),
        .overflow(overflow),
`ifdef DEMUX_FIFO_PAUSE_EN
        .pause(pause),
`endif
        .underflow(underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$], q1[$];
    logic [7:0] sb0[$], sb1[$];
    bit m_ovf, m_unf, ev0, ev1;

    typedef struct {
        bit v0; logic [7:0] d0; bit v1; logic [7:0] d1; bit p0; bit p1;
        int ecnt0; int ecnt1; bit evo0; logic [7:0] edo0;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decide(input int sz, input bit v, input bit p,
                                   output bit pu, output bit po, output bit ov, output bit un);
        po = p && (sz != 0);
        pu = v && ((sz != DEPTH) || p);
        ov = v && (sz == DEPTH) && !p;
        un = p && (sz == 0);
    endfunction

    task automatic step(input bit rst, input bit v0, input logic [7:0] d0,
                        input bit v1, input logic [7:0] d1, input bit p0, input bit p1);
        bit pu, po, ov, un;
        reset = rst; validIn0 = v0; dataIn0 = d0; validIn1 = v1; dataIn1 = d1;
        pop0 = p0; pop1 = p1;
        @(posedge clk);
        if (!rst) begin
            q0.delete(); q1.delete(); sb0.delete(); sb1.delete();
            m_ovf = 0; m_unf = 0; ev0 = 0; ev1 = 0;
        end else begin
            decide(q0.size(), v0, p0, pu, po, ov, un);
            if (ov) m_ovf = 1;
            if (un) m_unf = 1;
            ev0 = po;
            if (po) sb0.push_back(q0.pop_front());
            if (pu) q0.push_back(d0);
            decide(q1.size(), v1, p1, pu, po, ov, un);
            if (ov) m_ovf = 1;
            if (un) m_unf = 1;
            ev1 = po;
            if (po) sb1.push_back(q1.pop_front());
            if (pu) q1.push_back(d1);
        end
        #1;
        chk("validOut0", validOut0, ev0);
        chk("validOut1", validOut1, ev1);
        if (validOut0) begin
            if (sb0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dataOut0_spurious: got valid data %0h expected none", dataOut0);
            end else chk("dataOut0", dataOut0, sb0.pop_front());
        end
        if (validOut1) begin
            if (sb1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dataOut1_spurious: got valid data %0h expected none", dataOut1);
            end else chk("dataOut1", dataOut1, sb1.pop_front());
        end
        sb0.delete(); sb1.delete();
        chk("full0", full0, q0.size() == DEPTH);
        chk("full1", full1, q1.size() == DEPTH);
        chk("empty0", empty0, q0.size() == 0);
        chk("empty1", empty1, q1.size() == 0);
        chk("almost_full0", almost_full0, q0.size() >= AFT);
        chk("almost_full1", almost_full1, q1.size() >= AFT);
        chk("almost_empty0", almost_empty0, q0.size() <= AET);
        chk("almost_empty1", almost_empty1, q1.size() <= AET);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
`ifdef DEMUX_FIFO_PAUSE_EN
        chk("pause", pause, (q0.size() >= AFT) || (q1.size() >= AFT));
`endif
    endtask

    task automatic idle();
        step(1, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        tbl[0] = '{1, 8'hA1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00};
        tbl[1] = '{1, 8'hA2, 0, 8'h00, 0, 0, 2, 0, 0, 8'h00};
        tbl[2] = '{1, 8'hA3, 0, 8'h00, 0, 0, 3, 0, 0, 8'h00};
        tbl[3] = '{1, 8'hA4, 0, 8'h00, 0, 0, 4, 0, 0, 8'h00};
        tbl[4] = '{0, 8'h00, 0, 8'h00, 1, 0, 3, 0, 1, 8'hA1};
        tbl[5] = '{0, 8'h00, 0, 8'h00, 1, 0, 2, 0, 1, 8'hA2};
        tbl[6] = '{0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 8'hA3};
        tbl[7] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'hA4};
        tbl[8] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA4};

        // T1: reset held 3 cycles against pushes and pops
        for (int i = 0; i < 3; i++) step(0, 1, 8'hEE, 1, 8'hDD, 1, 1);
        chk("t1_dataOut0", dataOut0, 8'h00);
        chk("t1_dataOut1", dataOut1, 8'h00);
        idle();
        chk("t1_empty0_after", empty0, 1'b1);
        chk("t1_empty1_after", empty1, 1'b1);

        // T2: fill and drain lane 0 from the vector table
        for (int i = 0; i < 9; i++) begin
            step(1, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].p0, tbl[i].p1);
            chk("t2_full0", full0, tbl[i].ecnt0 == DEPTH);
            chk("t2_empty0", empty0, tbl[i].ecnt0 == 0);
            chk("t2_almost_full0", almost_full0, tbl[i].ecnt0 >= AFT);
            chk("t2_validOut0", validOut0, tbl[i].evo0);
            chk("t2_dataOut0", dataOut0, tbl[i].edo0);
            chk("t2_empty1", empty1, tbl[i].ecnt1 == 0);
        end

        // T3: overflow on full lane 1
        step(1, 0, 8'h00, 1, 8'h11, 0, 0);
        step(1, 0, 8'h00, 1, 8'h22, 0, 0);
        step(1, 0, 8'h00, 1, 8'h33, 0, 0);
        step(1, 0, 8'h00, 1, 8'h44, 0, 0);
        step(1, 0, 8'h00, 1, 8'h55, 0, 0);
        chk("t3_overflow", overflow, 1'b1);
        idle();
        chk("t3_overflow_sticky", overflow, 1'b1);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
        chk("t3_first", dataOut1, 8'h11);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
        chk("t3_last", dataOut1, 8'h44);
        idle();
        chk("t3_empty1", empty1, 1'b1);

        // T4: push+pop on full lane 0, pointers wrap
        step(1, 1, 8'hB1, 0, 8'h00, 0, 0);
        step(1, 1, 8'hB2, 0, 8'h00, 0, 0);
        step(1, 1, 8'hB3, 0, 8'h00, 0, 0);
        step(1, 1, 8'hB4, 0, 8'h00, 0, 0);
        step(1, 1, 8'h7E, 0, 8'h00, 1, 0);
        chk("t4_oldest", dataOut0, 8'hB1);
        chk("t4_still_full", full0, 1'b1);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 8'h00, 1, 0);
        chk("t4_7E_last", dataOut0, 8'h7E);

        // T5: underflow, then push+pop on empty lane 1
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
        chk("t5_underflow", underflow, 1'b1);
        chk("t5_no_valid", validOut1, 1'b0);
        step(1, 0, 8'h00, 1, 8'h66, 0, 1);
        chk("t5_stored", empty1, 1'b0);
        chk("t5_almost_empty1", almost_empty1, 1'b1);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
        chk("t5_data", dataOut1, 8'h66);

        // T6: pause follows almost_full of lane 1
        step(1, 0, 8'h00, 1, 8'hC1, 0, 0);
        step(1, 0, 8'h00, 1, 8'hC2, 0, 0);
        step(1, 0, 8'h00, 1, 8'hC3, 0, 0);
`ifdef DEMUX_FIFO_PAUSE_EN
        chk("t6_pause_set", pause, 1'b1);
`endif
        step(1, 0, 8'h00, 0, 8'h00, 0, 1);
`ifdef DEMUX_FIFO_PAUSE_EN
        chk("t6_pause_clr", pause, 1'b0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++)
            step(1, bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
                 8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        // Mid-stream reset clears state and sticky flags
        step(1, 1, 8'h91, 1, 8'h92, 0, 0);
        step(0, 1, 8'h93, 1, 8'h94, 1, 1);
        chk("rst_dataOut0", dataOut0, 8'h00);
        chk("rst_dataOut1", dataOut1, 8'h00);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
